// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: oversampling ratio, data-width base,
// TX/RX state encodings and a helper that masks a byte to the configured
// character width.
package uart_pkg;

    localparam int OVERSAMPLE     = 16;
    localparam int DATA_BITS_BASE = 5;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2
    } rx_state_t;

    // Selects the low (bits+5) bits of a character.
    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return 8'hFF >> (2'd3 - bits);
    endfunction

endpackage

// File: rtl/uart_core_fifo_if.sv
// Host-side handshake bundle for uart_core_fifo.
//   tx_valid/tx_data/tx_ready : push into the TX FIFO
//   rx_valid/rx_data/rx_perr/rx_ferr/rx_ready : RX FIFO head and pop
// master = host side, slave = UART core.
interface uart_core_fifo_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_ready;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_perr, rx_ferr
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_perr, rx_ferr
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
//   mclk, rst  : clock, async active-high reset
//   clr        : synchronous flush (wins over push/pop)
//   push/wdata : write; accepted when not full, or when full with a same-cycle pop
//   pop/rdata  : read; rdata shows the head entry, zero when empty
//   full/empty/cnt : status and occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_core_fifo.sv
// UART core with TX and RX FIFOs, 16x oversampling baud generator and
// per-frame configuration (5..8 data bits, optional parity, 1 or 2 stops).
//   mclk, rst          : clock, async active-high reset
//   cfg_*              : enable, data bits (value+5), stop2, parity enable/even, divisor
//   clr                : flush both FIFOs and clear rx_overrun
//   bus (slave)        : TX push and RX head/pop handshakes
//   rx_overrun         : sticky, set when a received character is dropped
//   tx_cnt, rx_cnt     : FIFO occupancy
//   txd, rxd, tx_busy  : serial line and transmitter activity
module uart_core_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                        mclk,
    input  logic                        rst,
    input  logic                        cfg_en,
    input  logic [1:0]                  cfg_data_bits,
    input  logic                        cfg_stop2,
    input  logic                        cfg_par_en,
    input  logic                        cfg_par_even,
    input  logic [DIV_W-1:0]            cfg_divisor,
    input  logic                        clr,
    uart_core_fifo_if.slave             bus,
    output logic                        rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0] tx_cnt,
    output logic [$clog2(FIFO_DEPTH):0] rx_cnt,
    output logic                        txd,
    input  logic                        rxd,
    output logic                        tx_busy
);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] LAST_BASE = 3'(DATA_BITS_BASE - 1);

    // Baud generator: down-counter, tick on terminal count.
    logic [DIV_W-1:0] baud_cnt;
    logic             tick;

    assign tick = cfg_en && (baud_cnt == '0);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst)                  baud_cnt <= '0;
        else if (!cfg_en)         baud_cnt <= cfg_divisor;
        else if (baud_cnt == '0)  baud_cnt <= cfg_divisor;
        else                      baud_cnt <= baud_cnt - 1'b1;
    end

    // FIFOs
    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_pop, rx_push;
    logic [9:0] rx_head, rx_wdata;

    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_head[7:0];
    assign bus.rx_perr  = rx_head[8];
    assign bus.rx_ferr  = rx_head[9];
    assign rx_pop       = bus.rx_ready && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .mclk(mclk), .rst(rst), .clr(clr),
        .push(bus.tx_valid && !tx_full), .pop(tx_pop),
        .wdata(bus.tx_data), .rdata(tx_head),
        .full(tx_full), .empty(tx_empty), .cnt(tx_cnt)
    );

    sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .mclk(mclk), .rst(rst), .clr(clr),
        .push(rx_push), .pop(rx_pop),
        .wdata(rx_wdata), .rdata(rx_head),
        .full(rx_full), .empty(rx_empty), .cnt(rx_cnt)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst)                                 rx_overrun <= 1'b0;
        else if (clr)                            rx_overrun <= 1'b0;
        else if (rx_push && rx_full && !rx_pop)  rx_overrun <= 1'b1;
    end

    // Transmitter. tx_pend marks a character taken from the FIFO that is
    // waiting for the next tick to start its frame.
    tx_state_t  tx_state;
    logic       tx_pend;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bcnt, tx_last;
    logic [7:0] tx_dat;
    logic       tx_par_en, tx_par_bit, tx_stop2;

    assign tx_pop = cfg_en && (tx_state == TX_IDLE) && !tx_pend && !tx_empty;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_pend    <= 1'b0;
            tx_tcnt    <= '0;
            tx_bcnt    <= '0;
            tx_last    <= '0;
            tx_dat     <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
        end else if (!cfg_en) begin
            tx_state <= TX_IDLE;
            tx_pend  <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_pend    <= 1'b1;
                        tx_busy    <= 1'b1;
                        tx_dat     <= tx_head;
                        tx_last    <= LAST_BASE + {1'b0, cfg_data_bits};
                        tx_par_en  <= cfg_par_en;
                        tx_par_bit <= ^(tx_head & data_mask(cfg_data_bits)) ^ ~cfg_par_even;
                        tx_stop2   <= cfg_stop2;
                    end else if (tx_pend && tick) begin
                        tx_pend  <= 1'b0;
                        tx_state <= TX_START;
                        tx_tcnt  <= '0;
                        txd      <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        if (tx_tcnt != TICK_LAST) begin
                            tx_tcnt <= tx_tcnt + 1'b1;
                        end else begin
                            tx_tcnt <= '0;
                            case (tx_state)
                                TX_START: begin
                                    tx_state <= TX_DATA;
                                    tx_bcnt  <= '0;
                                    txd      <= tx_dat[0];
                                end
                                TX_DATA: begin
                                    if (tx_bcnt != tx_last) begin
                                        tx_bcnt <= tx_bcnt + 1'b1;
                                        txd     <= tx_dat[tx_bcnt + 1'b1];
                                    end else if (tx_par_en) begin
                                        tx_state <= TX_PARITY;
                                        txd      <= tx_par_bit;
                                    end else begin
                                        tx_state <= TX_STOP1;
                                        txd      <= 1'b1;
                                    end
                                end
                                TX_PARITY: begin
                                    tx_state <= TX_STOP1;
                                    txd      <= 1'b1;
                                end
                                TX_STOP1: begin
                                    if (tx_stop2) begin
                                        tx_state <= TX_STOP2;
                                    end else begin
                                        tx_state <= TX_IDLE;
                                        tx_busy  <= 1'b0;
                                    end
                                end
                                default: begin
                                    tx_state <= TX_IDLE;
                                    tx_busy  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Receiver: rxd is asynchronous, so it goes through two flops first.
    logic [1:0] rx_sync;
    logic       rxs, rxs_d;

    assign rxs = rx_sync[1];

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rxs_d   <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rxs_d   <= rx_sync[1];
        end
    end

    rx_state_t  rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt, rx_last;
    logic [7:0] rx_sh;
    logic       rx_par_en, rx_par_even, rx_stop2, rx_perr_r, rx_ferr_r;

    assign rx_wdata = {rx_ferr_r, rx_perr_r, rx_sh};

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_tcnt     <= '0;
            rx_bcnt     <= '0;
            rx_last     <= '0;
            rx_sh       <= '0;
            rx_par_en   <= 1'b0;
            rx_par_even <= 1'b0;
            rx_stop2    <= 1'b0;
            rx_perr_r   <= 1'b0;
            rx_ferr_r   <= 1'b0;
            rx_push     <= 1'b0;
        end else if (!cfg_en) begin
            rx_state <= RX_IDLE;
            rx_push  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_state    <= RX_START;
                        rx_tcnt     <= '0;
                        rx_sh       <= '0;
                        rx_perr_r   <= 1'b0;
                        rx_ferr_r   <= 1'b0;
                        rx_last     <= LAST_BASE + {1'b0, cfg_data_bits};
                        rx_par_en   <= cfg_par_en;
                        rx_par_even <= cfg_par_even;
                        rx_stop2    <= cfg_stop2;
                    end
                end
                RX_START: begin
                    // Mid-point re-check rejects glitches shorter than half a bit.
                    if (tick) begin
                        if (rx_tcnt != TICK_MID) begin
                            rx_tcnt <= rx_tcnt + 1'b1;
                        end else if (rxs) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_tcnt  <= '0;
                            rx_bcnt  <= '0;
                            rx_state <= RX_DATA;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (rx_tcnt != TICK_LAST) begin
                            rx_tcnt <= rx_tcnt + 1'b1;
                        end else begin
                            rx_tcnt <= '0;
                            case (rx_state)
                                RX_DATA: begin
                                    rx_sh[rx_bcnt] <= rxs;
                                    if (rx_bcnt != rx_last)  rx_bcnt  <= rx_bcnt + 1'b1;
                                    else if (rx_par_en)      rx_state <= RX_PARITY;
                                    else                     rx_state <= RX_STOP1;
                                end
                                RX_PARITY: begin
                                    rx_perr_r <= (^rx_sh) ^ rxs ^ ~rx_par_even;
                                    rx_state  <= RX_STOP1;
                                end
                                RX_STOP1: begin
                                    if (!rxs) rx_ferr_r <= 1'b1;
                                    if (rx_stop2) begin
                                        rx_state <= RX_STOP2;
                                    end else begin
                                        rx_state <= RX_IDLE;
                                        rx_push  <= 1'b1;
                                    end
                                end
                                default: begin
                                    if (!rxs) rx_ferr_r <= 1'b1;
                                    rx_state <= RX_IDLE;
                                    rx_push  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_fifo.sv
// Directed bench for uart_core_fifo: reset state, loopback frames, parity,
// framing error, false start, overrun/clr, TX full and mid-frame reset.
module tb_uart_core_fifo;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        cfg_en = 1'b1;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic        cfg_stop2 = 1'b0;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_even = 1'b0;
    logic [15:0] cfg_divisor = 16'd0;
    logic        clr = 1'b0;
    logic        rx_overrun;
    logic [2:0]  tx_cnt, rx_cnt;
    logic        txd, rxd, tx_busy;
    logic        loop = 1'b1;
    logic        rxd_drv = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    uart_core_fifo_if bus();

    uart_core_fifo #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .mclk(mclk), .rst(rst), .cfg_en(cfg_en), .cfg_data_bits(cfg_data_bits),
        .cfg_stop2(cfg_stop2), .cfg_par_en(cfg_par_en), .cfg_par_even(cfg_par_even),
        .cfg_divisor(cfg_divisor), .clr(clr), .bus(bus), .rx_overrun(rx_overrun),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .txd(txd), .rxd(rxd), .tx_busy(tx_busy)
    );

    always #5 mclk = ~mclk;
    assign rxd = loop ? txd : rxd_drv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge mclk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge mclk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge mclk);
        bus.rx_ready = 1'b1;
        @(negedge mclk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        int n = 0;
        while (!bus.rx_valid && n < 400) begin
            @(negedge mclk);
            n++;
        end
        check_val({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        check_val({tag, "_data"},  32'(bus.rx_data),  32'(d));
        check_val({tag, "_perr"},  32'(bus.rx_perr),  32'(pe));
        check_val({tag, "_ferr"},  32'(bus.rx_ferr),  32'(fe));
        pop_rx();
    endtask

    // Records txd from the start bit; bits[k] is the mid-point of bit k,
    // len is the number of cycles from start-bit edge until tx_busy drops.
    task automatic tx_capture(input string tag, output logic [11:0] bits, output int len);
        logic trace [200];
        int   n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge mclk);
            n++;
        end
        check_val({tag, "_start"}, 32'(txd), 32'd0);
        len = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) @(negedge mclk);
            trace[i] = txd;
            if (len == 0 && !tx_busy) len = i;
        end
        for (int b = 0; b < 12; b++) bits[b] = trace[8 + 16 * b];
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                              input logic even, input logic stop2, input logic flip_par,
                              input logic bad_stop);
        logic p = 1'b0;
        rxd_drv = 1'b0;
        repeat (16) @(negedge mclk);
        for (int i = 0; i < nb; i++) begin
            rxd_drv = d[i];
            p = p ^ d[i];
            repeat (16) @(negedge mclk);
        end
        if (par_en) begin
            rxd_drv = p ^ ~even ^ flip_par;
            repeat (16) @(negedge mclk);
        end
        rxd_drv = ~bad_stop;
        repeat (16) @(negedge mclk);
        if (stop2) begin
            rxd_drv = 1'b1;
            repeat (16) @(negedge mclk);
        end
        rxd_drv = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bits;
        int          len;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge mclk);
        check_val("rst_txd",      32'(txd),          32'd1);
        check_val("rst_tx_busy",  32'(tx_busy),      32'd0);
        check_val("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_val("rst_rx_data",  32'(bus.rx_data),  32'd0);
        check_val("rst_rx_perr",  32'(bus.rx_perr),  32'd0);
        check_val("rst_rx_ferr",  32'(bus.rx_ferr),  32'd0);
        check_val("rst_overrun",  32'(rx_overrun),   32'd0);
        check_val("rst_tx_cnt",   32'(tx_cnt),       32'd0);
        check_val("rst_rx_cnt",   32'(rx_cnt),       32'd0);
        rst = 1'b0;
        repeat (4) @(negedge mclk);

        // 8N1 loopback 0xA5: frame = 0 | A5 | 1, 160 cycles
        push_tx(8'hA5);
        tx_capture("a5", bits, len);
        check_val("a5_frame", 32'(bits[9:0]), 32'h34A);
        check_val("a5_len",   32'(len),       32'd160);
        check_rx("a5_rx", 8'hA5, 1'b0, 1'b0);

        // 7E2 loopback 0x35: four ones -> even parity bit 0, 11 bits
        cfg_data_bits = 2'd2; cfg_par_en = 1'b1; cfg_par_even = 1'b1; cfg_stop2 = 1'b1;
        push_tx(8'h35);
        tx_capture("e35", bits, len);
        check_val("e35_frame",  32'(bits[10:0]), 32'h66A);
        check_val("e35_parity", 32'(bits[8]),    32'd0);
        check_val("e35_len",    32'(len),        32'd176);
        check_rx("e35_rx", 8'h35, 1'b0, 1'b0);

        // Same character, parity bit flipped on the line
        loop = 1'b0;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_rx("e35_flip", 8'h35, 1'b1, 1'b0);

        // 8N1 0x3C with stop bit low
        cfg_data_bits = 2'd3; cfg_par_en = 1'b0; cfg_par_even = 1'b0; cfg_stop2 = 1'b0;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rx("ferr_3c", 8'h3C, 1'b0, 1'b1);

        // 4-tick low glitch: rejected, receiver still usable afterwards
        rxd_drv = 1'b0;
        repeat (4) @(negedge mclk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge mclk);
        check_val("glitch_rx_cnt",   32'(rx_cnt),       32'd0);
        check_val("glitch_rx_valid", 32'(bus.rx_valid), 32'd0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_rx("glitch_next", 8'hC3, 1'b0, 1'b0);

        // Five characters into a 4-deep RX FIFO
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge mclk);
        check_val("ovr_rx_cnt", 32'(rx_cnt),     32'd4);
        check_val("ovr_flag",   32'(rx_overrun), 32'd1);
        check_rx("ovr_0", 8'h11, 1'b0, 1'b0);
        check_rx("ovr_1", 8'h22, 1'b0, 1'b0);
        check_rx("ovr_2", 8'h33, 1'b0, 1'b0);
        check_rx("ovr_3", 8'h44, 1'b0, 1'b0);
        check_val("ovr_sticky", 32'(rx_overrun), 32'd1);
        send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge mclk);
        check_val("ovr_refill_cnt", 32'(rx_cnt), 32'd1);
        clr = 1'b1;
        @(negedge mclk);
        clr = 1'b0;
        check_val("clr_rx_cnt",   32'(rx_cnt),       32'd0);
        check_val("clr_overrun",  32'(rx_overrun),   32'd0);
        check_val("clr_rx_valid", 32'(bus.rx_valid), 32'd0);

        // TX FIFO fills while disabled; clr empties it
        loop = 1'b1;
        cfg_en = 1'b0;
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        push_tx(8'h04);
        check_val("txfull_cnt",   32'(tx_cnt),       32'd4);
        check_val("txfull_ready", 32'(bus.tx_ready), 32'd0);
        check_val("txfull_idle",  32'(tx_busy),      32'd0);
        clr = 1'b1;
        @(negedge mclk);
        clr = 1'b0;
        check_val("txclr_cnt",   32'(tx_cnt),       32'd0);
        check_val("txclr_ready", 32'(bus.tx_ready), 32'd1);
        cfg_en = 1'b1;
        repeat (4) @(negedge mclk);

        // Reset in the middle of the data bits of 0xFF
        push_tx(8'hFF);
        push_tx(8'h81);
        begin
            int n = 0;
            while (txd !== 1'b0 && n < 100) begin
                @(negedge mclk);
                n++;
            end
        end
        repeat (40) @(negedge mclk);
        check_val("mid_busy",   32'(tx_busy), 32'd1);
        check_val("mid_tx_cnt", 32'(tx_cnt),  32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("abort_txd",    32'(txd),     32'd1);
        check_val("abort_busy",   32'(tx_busy), 32'd0);
        check_val("abort_tx_cnt", 32'(tx_cnt),  32'd0);
        @(negedge mclk);
        rst = 1'b0;
        repeat (4) @(negedge mclk);
        check_val("abort_rx_cnt", 32'(rx_cnt), 32'd0);
        push_tx(8'h5A);
        tx_capture("post", bits, len);
        check_val("post_frame", 32'(bits[9:0]), 32'h2B4);
        check_val("post_len",   32'(len),       32'd160);
        check_rx("post_rx", 8'h5A, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core_fifo.md
UART_CORE_FIFO -- requirements
Module: uart_core_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: entries per TX and RX FIFO; power of 2, 2..64.
REQ-002 SHALL have parameter DIV_W, default 16: width of baud divisor.
REQ-003 SHALL have port mclk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_en, input, 1: core enable.
REQ-006 SHALL have port cfg_data_bits, input, 2: data bits = value+5.
REQ-007 SHALL have port cfg_stop2, input, 1: 1 = two stop bits.
REQ-008 SHALL have port cfg_par_en, input, 1: parity enable.
REQ-009 SHALL have port cfg_par_even, input, 1: 1 = even, 0 = odd parity.
REQ-010 SHALL have port cfg_divisor, input, DIV_W: baud tick period = cfg_divisor+1 mclk.
REQ-011 SHALL have port clr, input, 1: synchronous flush of both FIFOs plus overrun clear.
REQ-012 SHALL have ports tx_valid (input, 1), tx_data (input, 8), tx_ready (output, 1): TX FIFO push.
REQ-013 SHALL have ports rx_valid (output, 1), rx_data (output, 8), rx_perr (output, 1), rx_ferr (output, 1), rx_ready (input, 1): RX FIFO head and pop.
REQ-014 SHALL have port rx_overrun, output, 1: sticky overrun flag.
REQ-015 SHALL have ports tx_cnt and rx_cnt, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-016 SHALL have ports txd (output, 1), rxd (input, 1, asynchronous), tx_busy (output, 1).

Function
REQ-017 Baud counter SHALL reload cfg_divisor and pulse tick at zero; 16 ticks per bit; counter and both FSMs held idle while cfg_en=0.
REQ-018 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP1, STOP2; each non-IDLE state lasts 16 ticks; PARITY skipped when cfg_par_en=0; STOP2 skipped when cfg_stop2=0.
REQ-019 In IDLE with TX FIFO non-empty and cfg_en=1, TX SHALL pop one entry, latch all cfg_* fields for the frame, and enter START on the next tick.
REQ-020 txd SHALL be 0 in START, data bits LSB first in DATA, parity bit in PARITY, 1 in IDLE/STOP1/STOP2; tx_busy=1 outside IDLE.
REQ-021 Parity bit SHALL equal XOR of the transmitted data bits for even, its inverse for odd.
REQ-022 rxd SHALL pass a 2-flop synchroniser; RX IDLE SHALL detect a 1->0 transition of the synchronised value and latch cfg_*.
REQ-023 RX SHALL re-sample at tick 8 of START; a 1 there is a false start: return to IDLE, push nothing.
REQ-024 RX SHALL sample data, parity and stop bits at 16-tick intervals from the START mid-point; unused upper rx_data bits SHALL be 0.
REQ-025 rx_perr SHALL flag a parity mismatch; rx_ferr SHALL flag stop bit 1 (or stop bit 2 when cfg_stop2=1) sampled 0; both are stored per entry with data.
REQ-026 RX SHALL push {ferr, perr, data} one mclk after the final stop sample, then return to IDLE.
REQ-027 tx_ready SHALL equal TX FIFO not full; push on tx_valid&&tx_ready; push and pop in the same cycle leave tx_cnt unchanged.
REQ-028 rx_valid SHALL equal RX FIFO not empty; pop on rx_valid&&rx_ready; outputs show head entry, zero latency.
REQ-029 RX push into a full FIFO SHALL drop the character and set rx_overrun, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-030 rx_overrun SHALL stay set until clr or rst; clr has priority over a same-cycle push or pop.
REQ-031 cfg_en falling mid-frame SHALL force both FSMs to IDLE next cycle, txd=1, abandoned characters lost, FIFO contents kept.

Reset
REQ-032 rst SHALL give txd=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_overrun=0, tx_cnt=0, rx_cnt=0, FSMs IDLE, synchroniser flops 1.
REQ-033 rst asserted mid-frame SHALL abort immediately; txd high within the reset assertion.

Structure
REQ-034 Package uart_pkg SHALL hold the TX/RX state enums, OVERSAMPLE=16, and DATA_BITS_BASE=5.
REQ-035 One sub-module sync_fifo (parameters WIDTH, DEPTH) SHALL be instantiated twice: TX width 8, RX width 10.

Verification
REQ-036 Loopback txd->rxd, divisor 0, 8N1, push 0xA5 -> txd frame 160 mclk, rx_data=0xA5, perr=0, ferr=0.
REQ-037 7E2, push 0x35 -> parity bit 0, frame 11 bits, rx_data=0x35, perr=0; flip parity on the line -> perr=1.
REQ-038 FIFO_DEPTH=4, receive 5 chars without pop -> rx_cnt=4, rx_overrun=1, first 4 retained in order; clr -> cnt 0, overrun 0.
REQ-039 Drive stop bit 1 low on 8N1 receive of 0x3C -> rx_data=0x3C, rx_ferr=1.
REQ-040 rxd low glitch of 4 ticks -> no push, RX back in IDLE.
REQ-041 Assert rst during DATA of TX 0xFF -> txd=1, tx_cnt=0, tx_busy=0; next push transmits a full clean frame.
